wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back sink of the pipeline: the block that consumes everything the MEM/WB pipeline register emits. It holds the 32 general-purpose registers and the HI/LO pair. It commits `wb_*` writes on the clock edge and serves two combinational read ports to the decode stage, with same-cycle write-through bypass. HI/LO committed values go to the execute stage.

## Interface
Parameters:
- `DW`, 32, data width (matches `RegBus`)
- `AW`, 5, register address width (matches `RegAddrBus`)
- `NREG`, 32, number of GPRs (2**AW)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `wb_wd`  in  AW  GPR write address
- `wb_wreg`  in  1  GPR write enable
- `wb_wdata`  in  DW  GPR write data
- `wb_hi`  in  DW  HI write data
- `wb_lo`  in  DW  LO write data
- `wb_hilo`  in  1  HI/LO write enable (writes both)
- `re1`  in  1  read port 1 enable
- `raddr1`  in  AW  read port 1 address
- `rdata1`  out  DW  read port 1 data (combinational)
- `re2`, `raddr2`, `rdata2`  in/in/out  1/AW/DW  read port 2, identical to port 1
- `hi_o`  out  DW  committed HI (registered)
- `lo_o`  out  DW  committed LO (registered)

## Operation
- GPR write: at posedge `clk`, if `!rst && wb_wreg && wb_wd != 0`, then `regs[wb_wd] <= wb_wdata`. Writes to r0 are discarded. r0 always reads 0.
- HI/LO write: at posedge, if `!rst && wb_hilo`, then `hi <= wb_hi` and `lo <= wb_lo`. The two are always written together, never separately.
- Read port n, evaluated in priority order:
  1. `rst` high → 0
  2. `raddrn == 0` → 0
  3. `!ren` → 0
  4. `wb_wreg && wb_wd == raddrn` → `wb_wdata` (bypass)
  5. otherwise → `regs[raddrn]`
- Both ports are independent. Both may hit the bypass in the same cycle and both then return `wb_wdata`.
- `hi_o`/`lo_o` have no bypass. They reflect state only; the execute stage forwards from MEM and WB itself.
- Zero-valued pipeline bubbles (`wb_wreg=0`, `wb_hilo=0`, `wb_wd=0`) must change no state.
- Reset (asynchronous assert): all 31 writable GPRs, `hi` and `lo` clear to 0 immediately, regardless of `clk`. `rdata1`, `rdata2`, `hi_o`, `lo_o` read 0 while `rst` is high.
- A write presented in the same cycle that `rst` asserts is lost.
- Reset deassertion is assumed synchronous to `clk` by the top-level reset synchronizer. The first write is accepted on the first posedge with `rst` low.

## Timing
- Read latency: 0 cycles (combinational from `raddr`/`re`/`wb_*`).
- Write-to-read: 0 cycles via bypass in the write cycle. From the array from the following cycle onward.
- HI/LO write-to-visible: 1 cycle (`hi_o` updates after the posedge that samples `wb_hilo=1`).
- Simultaneous GPR and HI/LO write in one cycle: both commit on the same edge.
- Same-address read on both ports during a write: both bypass and agree.
- No internal state machine. The GPR array and HI/LO are the only state.

## Structure
- Widths (`RegBus`, `RegAddrBus`), `zeroword`, `NOPRegAddr`, and `writeEnable`/`writeDisable` / `readEnable`/`readDisable` come from the shared `defines.v`; nothing new is defined locally.
- One natural sub-module: `hilo_reg`, the HI/LO pair with async reset and joint write enable. The GPR array and read/bypass muxing stay in `wb_regfile`.
- A single read-mux function/task is shared by both ports, so the port logic is not duplicated by hand.

## Test plan
- Reset clears state: write r5=0x1234, then pulse `rst` mid-cycle (no clock edge). `rdata1` reads 0 immediately. After release, `re1=1, raddr1=5` → 0.
- Write then read: cycle 0 `wb_wreg=1, wb_wd=7, wb_wdata=0xDEADBEEF` with `raddr1=7, re1=1`. `rdata1=0xDEADBEEF` in cycle 0 (bypass) and in cycle 1 (array, `wb_wreg=0`).
- r0 protection: write `wb_wd=0, wb_wdata=0xFFFFFFFF`. Same-cycle and next-cycle reads of r0 on both ports → 0.
- Read enable and port independence: r3=0x11, r4=0x22; `re1=0, raddr1=3; re2=1, raddr2=4` → `rdata1=0`, `rdata2=0x22`. Both ports at r9 during a write of 0x55 to r9 → both 0x55.
- HI/LO: `wb_hilo=1, wb_hi=0xA, wb_lo=0xB` in cycle 0. `hi_o/lo_o` are 0 in cycle 0 and 0xA/0xB from cycle 1. A bubble (`wb_hilo=0`, `wb_hi=0x99`) leaves them at 0xA/0xB.
- Reset mid-write: assert `rst` in the same cycle as a write of r12=0x77 → after release, r12 reads 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline widths and control encodings for the write-back register file.
// Both the top and the HI/LO sub-module import these so that widths and enables agree.
package wb_regfile_pkg;

    localparam int REG_BUS       = 32;
    localparam int REG_ADDR_BUS  = 5;

    localparam logic [REG_BUS-1:0]      ZERO_WORD     = '0;
    localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR  = '0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO pair: both halves load together on one enable and clear asynchronously on rst.
// Registered output, visible one cycle after the write; no bypass, never stalls.
module hilo_reg
    import wb_regfile_pkg::*;
#(
    parameter int DW = REG_BUS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [DW-1:0] i_hi,
    input  logic [DW-1:0] i_lo,
    output logic [DW-1:0] o_hi,
    output logic [DW-1:0] o_lo
);

    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_we == WRITE_ENABLE) begin
            r_hi <= i_hi;
            r_lo <= i_lo;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/wb_regfile.sv
// Write-back sink: 32 GPRs (r0 hardwired to zero) and HI/LO, two combinational read ports.
// Reads are zero-latency with same-cycle write-through bypass; writes commit every edge, no backpressure.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DW   = REG_BUS,
    parameter int AW   = REG_ADDR_BUS,
    parameter int NREG = 2**AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] wb_wd,
    input  logic          wb_wreg,
    input  logic [DW-1:0] wb_wdata,
    input  logic [DW-1:0] wb_hi,
    input  logic [DW-1:0] wb_lo,
    input  logic          wb_hilo,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    logic [DW-1:0] r_regs [NREG];
    logic          w_gpr_we;

    // r0 is never written, so its storage stays at the reset value of zero.
    assign w_gpr_we = (wb_wreg == WRITE_ENABLE) && (wb_wd != NOP_REG_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= ZERO_WORD;
            end
        end else if (w_gpr_we) begin
            r_regs[wb_wd] <= wb_wdata;
        end
    end

    // Priority: reset, r0, disabled port, in-flight write, then the array.
    function automatic logic [DW-1:0] rd_mux(
        input logic          f_rst,
        input logic          f_re,
        input logic [AW-1:0] f_raddr,
        input logic          f_wreg,
        input logic [AW-1:0] f_wd,
        input logic [DW-1:0] f_wdata,
        input logic [DW-1:0] f_array
    );
        logic [DW-1:0] v;
        v = f_array;
        if (f_rst) begin
            v = ZERO_WORD;
        end else if (f_raddr == NOP_REG_ADDR) begin
            v = ZERO_WORD;
        end else if (f_re == READ_DISABLE) begin
            v = ZERO_WORD;
        end else if ((f_wreg == WRITE_ENABLE) && (f_wd == f_raddr)) begin
            v = f_wdata;
        end
        return v;
    endfunction

    assign rdata1 = rd_mux(rst, re1, raddr1, wb_wreg, wb_wd, wb_wdata, r_regs[raddr1]);
    assign rdata2 = rd_mux(rst, re2, raddr2, wb_wreg, wb_wd, wb_wdata, r_regs[raddr2]);

    hilo_reg #(
        .DW (DW)
    ) u_hilo_reg (
        .clk  (clk),
        .rst  (rst),
        .i_we (wb_hilo),
        .i_hi (wb_hi),
        .i_lo (wb_lo),
        .o_hi (hi_o),
        .o_lo (lo_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile: reset, bypass, r0, port enables, HI/LO timing.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_hilo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_vec;
    int n_err;

    wb_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .wb_wd    (wb_wd),
        .wb_wreg  (wb_wreg),
        .wb_wdata (wb_wdata),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .wb_hilo  (wb_hilo),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Returns 1 time unit after the rising edge so checks never race the clock.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gpr_write(input logic [4:0] a, input logic [31:0] d);
        wb_wreg  = 1'b1;
        wb_wd    = a;
        wb_wdata = d;
        tick();
        wb_wreg  = 1'b0;
        wb_wd    = '0;
        wb_wdata = '0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        wb_wd = '0; wb_wreg = 1'b0; wb_wdata = '0;
        wb_hi = '0; wb_lo = '0; wb_hilo = 1'b0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

        // Reset state
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd31;
        #1;
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rdata2", rdata2, 32'h0);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // r5 write, then asynchronous reset pulse between edges
        gpr_write(5'd5, 32'h0000_1234);
        raddr1 = 5'd5; re1 = 1'b1;
        #1;
        chk("r5_stored", rdata1, 32'h0000_1234);
        #1 rst = 1'b1;
        #1;
        chk("r5_during_rst", rdata1, 32'h0);
        rst = 1'b0;
        #1;
        chk("r5_after_rst", rdata1, 32'h0);
        tick();

        // Write then read r7: bypass in the write cycle, array afterwards
        wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'hDEAD_BEEF;
        raddr1 = 5'd7; re1 = 1'b1;
        #1;
        chk("r7_bypass", rdata1, 32'hDEAD_BEEF);
        tick();
        wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
        #1;
        chk("r7_array", rdata1, 32'hDEAD_BEEF);

        // r0 protection
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        #1;
        chk("r0_same_p1", rdata1, 32'h0);
        chk("r0_same_p2", rdata2, 32'h0);
        tick();
        wb_wreg = 1'b0; wb_wdata = '0;
        #1;
        chk("r0_next_p1", rdata1, 32'h0);
        chk("r0_next_p2", rdata2, 32'h0);

        // Read enable and port independence
        gpr_write(5'd3, 32'h11);
        gpr_write(5'd4, 32'h22);
        re1 = 1'b0; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
        #1;
        chk("re1_off", rdata1, 32'h0);
        chk("p2_r4", rdata2, 32'h22);
        re1 = 1'b1;
        #1;
        chk("p1_r3", rdata1, 32'h11);

        // Both ports at r9 during a write, then a newer write must beat the stored value
        wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h55;
        raddr1 = 5'd9; raddr2 = 5'd9; re1 = 1'b1; re2 = 1'b1;
        #1;
        chk("r9_byp_p1", rdata1, 32'h55);
        chk("r9_byp_p2", rdata2, 32'h55);
        tick();
        wb_wdata = 32'h66;
        #1;
        chk("r9_newer_p1", rdata1, 32'h66);
        chk("r9_newer_p2", rdata2, 32'h66);
        wb_wreg = 1'b0;
        #1;
        chk("r9_off_byp", rdata1, 32'h55);
        tick();

        // HI/LO: one-cycle visibility, bubble holds
        wb_hilo = 1'b1; wb_hi = 32'hA; wb_lo = 32'hB;
        #1;
        chk("hi_c0", hi_o, 32'h0);
        chk("lo_c0", lo_o, 32'h0);
        tick();
        wb_hilo = 1'b0; wb_hi = 32'h99; wb_lo = 32'h98;
        #1;
        chk("hi_c1", hi_o, 32'hA);
        chk("lo_c1", lo_o, 32'hB);
        tick();
        chk("hi_bubble", hi_o, 32'hA);
        chk("lo_bubble", lo_o, 32'hB);

        // Simultaneous GPR and HI/LO commit, then a zero bubble
        wb_wreg = 1'b1; wb_wd = 5'd20; wb_wdata = 32'hCAFE;
        wb_hilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
        tick();
        wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
        wb_hilo = 1'b0; wb_hi = '0; wb_lo = '0;
        raddr1 = 5'd20; re1 = 1'b1; raddr2 = 5'd3; re2 = 1'b1;
        #1;
        chk("both_r20", rdata1, 32'hCAFE);
        chk("both_hi", hi_o, 32'h1);
        chk("both_lo", lo_o, 32'h2);
        tick();
        chk("bubble_r20", rdata1, 32'hCAFE);
        chk("bubble_r3", rdata2, 32'h11);
        chk("bubble_hi", hi_o, 32'h1);

        // Reset asserted in the same cycle as a write to r12
        wb_wreg = 1'b1; wb_wd = 5'd12; wb_wdata = 32'h77;
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
        raddr1 = 5'd12; re1 = 1'b1; raddr2 = 5'd20; re2 = 1'b1;
        #1;
        chk("r12_lost", rdata1, 32'h0);
        chk("r20_cleared", rdata2, 32'h0);
        chk("hi_cleared", hi_o, 32'h0);
        chk("lo_cleared", lo_o, 32'h0);

        // First write accepted on the first edge after release
        gpr_write(5'd12, 32'h88);
        #1;
        chk("r12_post_rst", rdata1, 32'h88);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
